// File: rtl/rapid_fetch_unit.sv
// ---------------------------------------------------------------------------
// rapid_fetch_unit
//
// Instruction fetch front end. A four-state FSM (FETCH -> WAIT -> NEXT)
// issues one memory request at a time at the current PC. It pushes each
// returned word, tagged with its PC, into a small circular prefetch queue.
// A redirect flushes the queue and restarts fetch at a new PC. If the
// redirect lands while a response is still outstanding, that response is
// marked for discard. A fetch error or a halt request parks the FSM in HALT
// until resume.
//
// Handshake semantics:
//   - Memory side: mem_req is held high for the whole of WAIT. The memory
//     answers each request with exactly one mem_valid cycle.
//   - Consumer side: the head entry moves when inst_valid && inst_ready are
//     both high at a rising edge. inst_valid is forced low during a redirect
//     cycle, so a flushed entry can never be consumed.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mem_req, mem_addr          fetch request and address (address is the PC)
//   mem_valid, mem_rdata,
//   mem_err                    memory response strobe, data and error
//   redirect_valid,
//   redirect_pc                branch/flush request and target
//   halt_req, resume           stop fetching at the next NEXT / leave HALT
//   inst_valid, inst_ready,
//   inst_data, inst_pc         prefetch queue head
//   fetch_err                  sticky fetch-error flag, cleared by redirect
//   fetch_state                registered FSM state (FETCH=0 WAIT=1 NEXT=2 HALT=3)
// ---------------------------------------------------------------------------
module rapid_fetch_unit #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter int                QUEUE_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             mem_req,
    output logic [XLEN-1:0]  mem_addr,
    input  logic             mem_valid,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_err,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             halt_req,
    input  logic             resume,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst_data,
    output logic [XLEN-1:0]  inst_pc,
    output logic             fetch_err,
    output logic [1:0]       fetch_state
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_NEXT  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t             state;
    logic [XLEN-1:0]    pc;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               discard;
    logic               halt_pend;
    logic               err_flag;

    logic [31:0]        data_mem [QUEUE_DEPTH];
    logic [XLEN-1:0]    pc_mem   [QUEUE_DEPTH];

    logic               push;
    logic               pop;
    logic [XLEN-1:0]    redirect_target;
    logic               redirect_lsb_unused;

    // Instruction targets are word aligned; the low two bits of a redirect
    // target carry no information.
    assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // A response in the same cycle as a redirect belongs to the old stream.
    assign push = (state == ST_WAIT) && mem_valid && !discard && !mem_err &&
                  !redirect_valid;
    assign inst_valid = (count != '0) && !redirect_valid;
    assign pop        = inst_valid && inst_ready;

    assign mem_req     = (state == ST_WAIT);
    assign mem_addr    = pc;
    assign inst_data   = data_mem[rd_ptr];
    assign inst_pc     = pc_mem[rd_ptr];
    assign fetch_err   = err_flag;
    assign fetch_state = state;

    // Queue payload storage; validity is tracked by count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= mem_rdata;
            pc_mem[wr_ptr]   <= pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            pc        <= RESET_VECTOR;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            discard   <= 1'b0;
            halt_pend <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            // Queue bookkeeping. Pointers wrap naturally at QUEUE_DEPTH
            // because the depth is a power of two.
            if (redirect_valid) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !pop)
                    count <= count + CNT_W'(1);
                else if (pop && !push)
                    count <= count - CNT_W'(1);
            end

            case (state)
                ST_FETCH: begin
                    if (halt_req) halt_pend <= 1'b1;
                    if (count < CNT_W'(QUEUE_DEPTH)) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (halt_req) halt_pend <= 1'b1;
                    if (mem_valid) begin
                        if (discard) begin
                            discard <= 1'b0;
                            state   <= ST_FETCH;
                        end else if (mem_err) begin
                            err_flag  <= 1'b1;
                            halt_pend <= 1'b0;
                            state     <= ST_HALT;
                        end else begin
                            state <= ST_NEXT;
                        end
                    end
                end
                ST_NEXT: begin
                    pc <= pc + XLEN'(4);
                    if (halt_req || halt_pend) begin
                        halt_pend <= 1'b0;
                        state     <= ST_HALT;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    if (resume) state <= ST_FETCH;
                end
                default: state <= ST_FETCH;
            endcase

            // Redirect overrides every normal transition above.
            if (redirect_valid) begin
                pc        <= redirect_target;
                err_flag  <= 1'b0;
                halt_pend <= 1'b0;
                case (state)
                    ST_WAIT: begin
                        if (mem_valid) begin
                            // Response for the old stream arrives now: drop it.
                            discard <= 1'b0;
                            state   <= ST_FETCH;
                        end else begin
                            // Keep the bus request open until the stale
                            // response returns, then throw it away.
                            discard <= 1'b1;
                            state   <= ST_WAIT;
                        end
                    end
                    ST_HALT: state <= ST_HALT;
                    default: state <= ST_FETCH;
                endcase
            end
        end
    end

endmodule

// File: doc/rapid_fetch_unit.md
RAPID_FETCH_UNIT -- requirements
Module: rapid_fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 0, first fetch address after reset.
REQ-002 Parameter XLEN, default 32, PC and address width.
REQ-003 Parameter QUEUE_DEPTH, default 4, prefetch queue entries; power of two, >= 2.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous and active-low.
REQ-006 mem_req  output  1  fetch request; held high until the response arrives.
REQ-007 mem_addr  output  XLEN  fetch address; equals PC; stable while mem_req is high.
REQ-008 mem_valid  input  1  response strobe; one cycle per request.
REQ-009 mem_rdata  input  32  instruction word; valid with mem_valid.
REQ-010 mem_err  input  1  response error; sampled with mem_valid.
REQ-011 redirect_valid  input  1  branch or flush request.
REQ-012 redirect_pc  input  XLEN  new PC for a redirect.
REQ-013 halt_req  input  1  stop fetching at the next NEXT state.
REQ-014 resume  input  1  leave HALT.
REQ-015 inst_valid  output  1  queue head valid.
REQ-016 inst_ready  input  1  consumer accepts the head.
REQ-017 inst_data  output  32  queue head instruction.
REQ-018 inst_pc  output  XLEN  queue head PC.
REQ-019 fetch_err  output  1  sticky fetch-error flag.
REQ-020 fetch_state  output  2  current state, encoded FETCH=0, WAIT=1, NEXT=2, HALT=3.

Function
REQ-021 FSM state FETCH: if queue count < QUEUE_DEPTH, go to WAIT; otherwise stay in FETCH.
REQ-022 FSM state WAIT: mem_req = 1 and mem_addr = PC; on mem_valid, push {PC, mem_rdata} unless the discard flag is set.
  - After a push, go to NEXT.
  - After a discarded response, clear the discard flag and go to FETCH.
REQ-023 mem_req SHALL be high only in WAIT while no response has arrived; at most one request is outstanding.
REQ-024 FSM state NEXT: PC <= PC + 4, modulo 2^XLEN (wrap-around permitted); go to HALT if halt_req is high or a halt is pending, else go to FETCH.
REQ-025 FSM state HALT: no requests; resume moves to FETCH on the next cycle.
REQ-026 A halt_req seen in FETCH or WAIT SHALL be latched as pending and honoured at the next NEXT state; the pending bit clears on entry to HALT.
REQ-027 redirect_valid in any state SHALL, in that cycle:
  - flush the queue (count <= 0);
  - set PC <= redirect_pc with bits [1:0] forced to 0;
  - clear fetch_err and any pending halt.
REQ-028 Redirect next state:
  - from FETCH or NEXT: go to FETCH;
  - from WAIT without a response that cycle: set discard and stay in WAIT;
  - from WAIT with mem_valid in the same cycle: drop the response and go to FETCH;
  - from HALT: stay in HALT.
REQ-029 inst_valid SHALL be (count != 0) AND NOT redirect_valid; a pop occurs only when inst_valid and inst_ready are both high.
REQ-030 A push and a pop in the same cycle SHALL leave count unchanged; the queue is a circular buffer with log2(QUEUE_DEPTH)-bit wrapping pointers.
REQ-031 mem_valid with mem_err (not discarded) SHALL push nothing, set fetch_err, and go to HALT.
REQ-032 Latency: a redirect in cycle N SHALL give mem_req with the new address in cycle N+2, or later if the queue is full or a discard is pending.
REQ-033 fetch_state SHALL reflect the registered state.

Reset
REQ-034 While rst_n is low:
  - state = FETCH, PC = RESET_VECTOR, count = 0;
  - all pointers, the discard flag, halt pending and fetch_err = 0;
  - mem_req = 0 and inst_valid = 0.
REQ-035 Reset asserted mid-request SHALL abandon the request immediately; a late mem_valid arriving in FETCH, NEXT or HALT SHALL be ignored.
REQ-036 With rst_n released at cycle 0, the first mem_req SHALL appear in cycle 1 with mem_addr = RESET_VECTOR.

Verification
REQ-037 Streaming: inst_ready = 1, 1-cycle memory, RESET_VECTOR = 0x100 -> inst_pc sequence 0x100, 0x104, 0x108, ..., with rdata preserved.
REQ-038 Backpressure: inst_ready = 0, QUEUE_DEPTH = 4 -> exactly 4 pushes, then FSM stays in FETCH with mem_req = 0; one pop -> exactly one more request.
REQ-039 Redirect in WAIT: redirect_pc = 0x202 while a response is outstanding -> that response is dropped, queue empty, next mem_addr = 0x200.
REQ-040 Error: mem_err on the response for 0x10 -> fetch_err = 1, state HALT, no push; redirect to 0x40 plus resume -> fetch_err = 0, fetch at 0x40.
REQ-041 Halt/resume: halt_req pulsed in WAIT -> one more push, then HALT with no requests; resume -> fetch continues at the next sequential PC.
REQ-042 Wrap: PC = 0xFFFFFFFC -> next fetch address 0x00000000.
